// File: rtl/video_to_ram_pkg.sv
// rtl/video_to_ram_pkg.sv - capture window constants and ring address helper
// Shared by the capture side, the readout side and the bench so all agree on the raster layout.
package video_to_ram_pkg;

  localparam int H_CAPTURE_START  = 0;
  localparam int H_CAPTURE_END    = 640;
  localparam int V_CAPTURE_START  = 0;
  localparam int V_CAPTURE_END    = 480;
  localparam int LD_FIELD2_START  = 263;
  localparam int LD_V_CAPTURE_END = 503;
  localparam int LD_FIELD_LINES   = 240;
  localparam int BUFFER_LINES     = 48;
  localparam int LINE_WIDTH       = H_CAPTURE_END - H_CAPTURE_START;
  localparam int TRIGGER_LINE     = 4;
  localparam int RAM_ADDRESS_BITS = 15;

  localparam int SLOT_BITS        = $clog2(BUFFER_LINES);
  localparam int LINE_CNT_BITS    = 10;

  typedef logic [SLOT_BITS-1:0]        slot_t;
  typedef logic [LINE_CNT_BITS-1:0]    line_cnt_t;
  typedef logic [RAM_ADDRESS_BITS-1:0] ram_addr_t;

  typedef struct packed {
    logic capture;
    logic line_end;
    logic slot_reset;
    logic first_pixel;
  } capture_ctrl_t;

  function automatic ram_addr_t ring_addr(input slot_t slot, input logic [11:0] x);
    int a;
    a = int'(32'(slot)) * LINE_WIDTH + int'(32'(x)) - H_CAPTURE_START;
    return ram_addr_t'(a);
  endfunction

endpackage

// File: rtl/video_to_ram_addr_gen.sv
// rtl/video_to_ram_addr_gen.sv - line-ring slot, captured-line count, write address and start trigger
module capture_addr_gen
  import video_to_ram_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  capture_ctrl_t i_ctrl,
  input  logic [11:0]   i_x,
  output ram_addr_t     o_addr,
  output logic          o_trigger
);

  slot_t     r_slot;
  line_cnt_t r_line;
  slot_t     w_slot;
  line_cnt_t w_line;

  // The reset point coincides with the first pixel, so that pixel must already see slot 0.
  always_comb begin
    w_slot    = i_ctrl.slot_reset ? '0 : r_slot;
    w_line    = i_ctrl.slot_reset ? '0 : r_line;
    o_addr    = ring_addr(w_slot, i_x);
    o_trigger = i_ctrl.capture && i_ctrl.first_pixel
                && (w_line == line_cnt_t'(TRIGGER_LINE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_slot <= '0;
      r_line <= '0;
    end else if (i_ctrl.slot_reset) begin
      r_slot <= '0;
      r_line <= '0;
    end else if (i_ctrl.line_end) begin
      r_slot <= (r_slot == slot_t'(BUFFER_LINES - 1)) ? '0 : r_slot + 1'b1;
      // Saturating so the trigger line index can never recur within one frame.
      if (r_line != '1) begin
        r_line <= r_line + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_to_ram.sv
// rtl/video_to_ram.sv - captures the active pixel window into the line-ring RAM
module video_to_ram
  import video_to_ram_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  R,
  input  logic [7:0]                  G,
  input  logic [7:0]                  B,
  input  logic [11:0]                 counterX,
  input  logic [11:0]                 counterY,
  input  logic                        line_doubler,
  output logic [23:0]                 wrdata,
  output logic [RAM_ADDRESS_BITS-1:0] wraddr,
  output logic                        wren,
  output logic                        wrclock,
  output logic                        starttrigger
);

  int            w_x;
  int            w_y;
  logic          w_vwin;
  logic          w_hwin;
  capture_ctrl_t w_ctrl;
  ram_addr_t     w_addr;
  logic          w_trigger;

  logic [23:0]   r_wrdata;
  ram_addr_t     r_wraddr;
  logic          r_wren;
  logic          r_starttrigger;

  always_comb begin
    w_x = int'(32'(counterX));
    w_y = int'(32'(counterY));
    if (line_doubler) begin
      w_vwin = (w_y < LD_FIELD_LINES)
               || (w_y >= LD_FIELD2_START && w_y < LD_V_CAPTURE_END);
    end else begin
      w_vwin = (w_y >= V_CAPTURE_START) && (w_y < V_CAPTURE_END);
    end
    w_hwin = (w_x >= H_CAPTURE_START) && (w_x < H_CAPTURE_END);

    w_ctrl.capture     = w_vwin && w_hwin;
    w_ctrl.line_end    = w_vwin && (w_x == H_CAPTURE_END);
    w_ctrl.first_pixel = (w_x == H_CAPTURE_START);
    // Each doubler field restarts the ring so both fields share the same readout schedule.
    if (line_doubler) begin
      w_ctrl.slot_reset = (w_x == 0) && (w_y == 0 || w_y == LD_FIELD2_START);
    end else begin
      w_ctrl.slot_reset = (w_x == 0) && (w_y == V_CAPTURE_START);
    end
  end

  capture_addr_gen u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .i_ctrl    (w_ctrl),
    .i_x       (counterX),
    .o_addr    (w_addr),
    .o_trigger (w_trigger)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrdata       <= '0;
      r_wraddr       <= '0;
      r_wren         <= 1'b0;
      r_starttrigger <= 1'b0;
    end else begin
      r_wren         <= w_ctrl.capture;
      r_starttrigger <= w_trigger;
      if (w_ctrl.capture) begin
        r_wrdata <= {R, G, B};
        r_wraddr <= w_addr;
      end
    end
  end

  assign wrdata       = r_wrdata;
  assign wraddr       = r_wraddr;
  assign wren         = r_wren;
  assign starttrigger = r_starttrigger;
  assign wrclock      = clock;

endmodule

// File: tb/tb_video_to_ram.sv
// tb/tb_video_to_ram.sv - vector table plus raster-model scoreboard for video_to_ram
module tb_video_to_ram;
  import video_to_ram_pkg::*;

  typedef struct {
    logic        wren;
    int          addr;
    logic [23:0] data;
    logic        trig;
    int          x;
    int          y;
  } exp_t;

  typedef struct {
    logic        rst;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        wren;
    int          addr;
    logic [23:0] data;
    logic        trig;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  R = '0, G = '0, B = '0;
  logic [11:0] counterX = '0, counterY = '0;
  logic        line_doubler = 1'b0;
  logic [23:0] wrdata;
  logic [RAM_ADDRESS_BITS-1:0] wraddr;
  logic        wren, wrclock, starttrigger;

  always #5 clock = ~clock;

  video_to_ram dut (
    .clock        (clock),
    .reset        (reset),
    .R            (R),
    .G            (G),
    .B            (B),
    .counterX     (counterX),
    .counterY     (counterY),
    .line_doubler (line_doubler),
    .wrdata       (wrdata),
    .wraddr       (wraddr),
    .wren         (wren),
    .wrclock      (wrclock),
    .starttrigger (starttrigger)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          trig_cnt = 0;
  int          coll = 0;
  int          rline = 0;
  bit          r_act = 0;
  int          m_addr = 0;
  logic [23:0] m_data = '0;
  int          xs[9] = '{0, 1, 5, 320, 638, 639, 640, 641, 857};
  vec_t        tv[14];

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic apply(input logic rst, input int x, input int y, input logic ld,
                       input logic [23:0] rgb, input exp_t e);
    exp_t got;
    reset        = rst;
    counterX     = x[11:0];
    counterY     = y[11:0];
    line_doubler = ld;
    {R, G, B}    = rgb;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    checks++;
    if (wren !== got.wren || wraddr !== RAM_ADDRESS_BITS'(got.addr)
        || wrdata !== got.data || starttrigger !== got.trig) begin
      failures++;
      $display("FAIL pix x=%0d y=%0d actual wren=%0b addr=%0d data=%06h trig=%0b required wren=%0b addr=%0d data=%06h trig=%0b",
               got.x, got.y, wren, wraddr, wrdata, starttrigger,
               got.wren, got.addr, got.data, got.trig);
    end
    if (starttrigger === 1'b1) trig_cnt++;
  endtask

  task automatic run_pix(input int x, input int y, input logic ld, input logic [23:0] rgb);
    bit   vwin, cap;
    int   idx, raddr;
    exp_t e;
    vwin  = ld ? (y < 240 || (y >= 263 && y < 503)) : (y < 480);
    cap   = vwin && (x < 640);
    idx   = (ld && y >= 263) ? y - 263 : y;
    raddr = (rline % 48) * 640 + x;
    if (cap) begin
      m_addr = (idx % 48) * 640 + x;
      m_data = rgb;
    end
    e = '{cap, m_addr, m_data, cap && x == 0 && idx == 4, x, y};
    apply(1'b0, x, y, ld, rgb, e);
    if (r_act && wren === 1'b1 && x < 640 && wraddr == RAM_ADDRESS_BITS'(raddr)) coll++;
    if (starttrigger === 1'b1) begin
      r_act = 1;
      rline = 0;
    end else if (r_act && vwin && x == 640) begin
      rline++;
    end
  endtask

  task automatic run_frame(input logic ld);
    logic [23:0] rgb;
    trig_cnt = 0;
    coll     = 0;
    r_act    = 0;
    rline    = 0;
    for (int y = 0; y < 525; y++) begin
      for (int k = 0; k < 9; k++) begin
        rgb = {y[7:0] ^ 8'h5A, xs[k][7:0], 8'hC3};
        run_pix(xs[k], y, ld, rgb);
        if (!ld && xs[k] == 0 && y == 47) chk("wrap47", wraddr == 15'd30080, int'(wraddr), 30080);
        if (!ld && xs[k] == 0 && y == 48) chk("wrap48", wren && wraddr == 15'd0, int'(wraddr), 0);
        if (!ld && xs[k] == 0 && y == 4)  chk("trig_p", starttrigger && wraddr == 15'd2560, int'(wraddr), 2560);
        if (ld && xs[k] == 0 && y == 263) chk("field2", wren && wraddr == 15'd0, int'(wraddr), 0);
        if (ld && xs[k] == 0 && y == 267) chk("trig_f2", starttrigger == 1'b1, int'(starttrigger), 1);
      end
    end
    chk(ld ? "trig_count_ld" : "trig_count_p", trig_cnt == (ld ? 2 : 1), trig_cnt, ld ? 2 : 1);
    chk("collisions", coll == 0, coll, 0);
  endtask

  initial begin
    tv[0]  = '{1'b1,   0,   0, 24'h000000, 1'b0,   0, 24'h000000, 1'b0};
    tv[1]  = '{1'b0,   0,   0, 24'h112233, 1'b1,   0, 24'h112233, 1'b0};
    tv[2]  = '{1'b0, 300,   0, 24'h445566, 1'b1, 300, 24'h445566, 1'b0};
    tv[3]  = '{1'b1, 301,   0, 24'h445566, 1'b0,   0, 24'h000000, 1'b0};
    tv[4]  = '{1'b1, 302,   0, 24'h445566, 1'b0,   0, 24'h000000, 1'b0};
    tv[5]  = '{1'b1, 303,   0, 24'h445566, 1'b0,   0, 24'h000000, 1'b0};
    tv[6]  = '{1'b0,   0,   0, 24'h112233, 1'b1,   0, 24'h112233, 1'b0};
    tv[7]  = '{1'b0, 639,   0, 24'h112233, 1'b1, 639, 24'h112233, 1'b0};
    tv[8]  = '{1'b0, 640,   0, 24'h112233, 1'b0, 639, 24'h112233, 1'b0};
    tv[9]  = '{1'b0,   5,   1, 24'h112233, 1'b1, 645, 24'h112233, 1'b0};
    tv[10] = '{1'b0, 857, 524, 24'h778899, 1'b0, 645, 24'h112233, 1'b0};
    tv[11] = '{1'b0,   0, 480, 24'h778899, 1'b0, 645, 24'h112233, 1'b0};
    tv[12] = '{1'b0, 900,   0, 24'h778899, 1'b0, 645, 24'h112233, 1'b0};
    tv[13] = '{1'b0,   0, 600, 24'h778899, 1'b0, 645, 24'h112233, 1'b0};

    for (int i = 0; i < 14; i++) begin
      apply(tv[i].rst, tv[i].x, tv[i].y, 1'b0, tv[i].rgb,
            '{tv[i].wren, tv[i].addr, tv[i].data, tv[i].trig, tv[i].x, tv[i].y});
    end
    m_addr = 645;
    m_data = 24'h112233;

    run_frame(1'b0);
    run_frame(1'b0);
    run_frame(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_to_ram.md
Name: video_to_ram

Overview:
- Captures the active window of the incoming Dreamcast pixel stream into the dual-port frame/line RAM.
- Stream is 858x525 total raster, RGB888, with raster counters supplied by the timing block.
- Produces RAM write data/address/enable on a line-ring buffer.
- Issues a per-frame start pulse that is crossed into the output clock domain to launch RAM readout for HDMI.

Parameters:
- H_CAPTURE_START, 0, first captured counterX (inclusive).
- H_CAPTURE_END, 640, last captured counterX + 1.
- V_CAPTURE_START, 0, first captured counterY in progressive mode.
- V_CAPTURE_END, 480, last captured counterY + 1 in progressive mode.
- LD_FIELD2_START, 263, first captured counterY of field 2 in line-doubler mode.
- LD_V_CAPTURE_END, 503, last captured counterY + 1 of field 2 in line-doubler mode.
- LD_FIELD_LINES, 240, captured lines per field (field 1 is counterY 0..239).
- BUFFER_LINES, 48, lines held in the RAM ring.
- LINE_WIDTH, 640, equals H_CAPTURE_END - H_CAPTURE_START.
- TRIGGER_LINE, 4, captured-line index (0-based) whose first pixel fires starttrigger.
- RAM_ADDRESS_BITS, 15, RAM address width; must satisfy LINE_WIDTH*BUFFER_LINES <= 2^RAM_ADDRESS_BITS.

Ports:
- clock  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- R  in  8  red.
- G  in  8  green.
- B  in  8  blue.
- counterX  in  12  horizontal raster position, 0..857.
- counterY  in  12  vertical raster position, 0..524.
- line_doubler  in  1  1 = 480i two-field capture, 0 = progressive capture.
- wrdata  out  24  {R,G,B} registered.
- wraddr  out  RAM_ADDRESS_BITS  RAM write address.
- wren  out  1  RAM write enable.
- wrclock  out  1  RAM write clock; combinational copy of clock.
- starttrigger  out  1  one-cycle start pulse.

Behaviour:
- Reset (synchronous, active-high): next edge clears wrdata, wraddr, wren, starttrigger, line slot and captured-line counter to 0. Reset mid-line aborts the line; the first full frame after reset restarts from slot 0.
- Vertical capture window:
  - line_doubler=0: V_CAPTURE_START <= y < V_CAPTURE_END.
  - line_doubler=1: y < LD_FIELD_LINES, or LD_FIELD2_START <= y < LD_V_CAPTURE_END.
- Capture time: vertical window true and H_CAPTURE_START <= x < H_CAPTURE_END.
- Single pipeline stage, 1-cycle latency. On the edge where inputs show a capture-time pixel:
  - wren=1;
  - wrdata={R,G,B};
  - wraddr = slot*LINE_WIDTH + (x - H_CAPTURE_START), truncated to RAM_ADDRESS_BITS.
- Otherwise wren=0, and wrdata/wraddr hold their last value.
- Slot (0..BUFFER_LINES-1):
  - Forced to 0 at the cycle x==0 of y==V_CAPTURE_START (progressive), or y==0 and y==LD_FIELD2_START (doubler).
  - Otherwise increments, wrapping BUFFER_LINES-1 -> 0, on x==H_CAPTURE_END of each captured line.
- Captured-line counter: same reset points as slot; increments at the same instant, but saturates instead of wrapping.
- starttrigger: 1 for exactly the cycle in which wren is asserted for the first pixel (x==H_CAPTURE_START) of captured line TRIGGER_LINE. Fires once per frame (progressive) or once per field (doubler); 0 at all other times.
- line_doubler changes take effect at the next slot-reset point; a mid-frame change may corrupt that frame only.
- Out-of-range counters (x>=858 or y>=525) are not captured; no wren.

Decomposition:
- Shared package: all capture/window constants, BUFFER_LINES, LINE_WIDTH, TRIGGER_LINE, RAM_ADDRESS_BITS. The same values are used by the ram2video readout and the testbench.
- One natural sub-module: capture_addr_gen (slot, line counter, address arithmetic, trigger). Top level holds the window decode and output registers.

Test Plan:
- Reset held 3 cycles mid-line -> wren=0, wraddr=0, starttrigger=0 on the cycle after each reset edge.
- Progressive frame with R/G/B=0x11/0x22/0x33:
  - x=0,y=0 -> next cycle wren=1, wraddr=0, wrdata=0x112233;
  - x=639,y=0 -> wraddr=639;
  - x=640 -> wren=0;
  - x=5,y=1 -> wraddr=645.
- Ring wrap, progressive: y=47,x=0 -> wraddr=30080; y=48,x=0 -> wraddr=0; y=480 -> no wren all line.
- Trigger, progressive: exactly one pulse per frame, coincident with the wren at y=4,x=0 (wraddr=2560). None during y=0..3 or y>4.
- Line doubler=1:
  - y=239 captured; y=240..262 not captured;
  - y=263,x=0 -> wraddr=0;
  - trigger pulses at y=4 and y=267, x=0;
  - y=503 not captured.
- Continuous run with a second-domain readout sharing the ring: over 2 frames, wraddr never equals the active read address while both are in active area.
